// File: rtl/vram_write_scheduler.sv
// Shares the VRAM CPU write port between a full-screen fill engine and a game-logic request port.
// Writes are only issued inside the blanking window that each vsync_ready pulse opens.
module vram_write_scheduler #(
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned DATA_W        = 2,
  parameter int unsigned CELLS         = 1200,
  parameter int unsigned WINDOW_CYCLES = 144000
) (
  input  logic              sys_clock,
  input  logic              reset_n,
  input  logic              vsync_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              req_oor,
  output logic              window_open,
  output logic              cpu_we,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data
);

  localparam int unsigned CntW = $clog2(WINDOW_CYCLES);
  localparam logic [CntW-1:0]   CntLast  = CntW'(WINDOW_CYCLES - 1);
  localparam logic [ADDR_W-1:0] FillLast = ADDR_W'(CELLS - 1);

  typedef enum logic {StClosed, StOpen} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Round-robin pointer: 0 = FILL has priority, 1 = REQ has priority.
  logic rr_req_q, rr_req_d;

  logic              fill_busy_q, fill_busy_d;
  logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;

  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              req_oor_q, req_oor_d;

  logic open;
  logic fill_gnt;
  logic req_gnt;
  logic contended;
  logic req_in_range;

  // ---------------------------------------------------------------------------
  // Window FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClosed;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClosed: begin
        if (vsync_ready) begin
          state_d = StOpen;
          cnt_d   = '0;
        end
      end
      StOpen: begin
        // A fresh vsync_ready extends the window instead of closing it.
        if (vsync_ready) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StClosed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StClosed;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    open         = (state_q == StOpen);
    window_open  = open;
    contended    = open && fill_busy_q && req_valid;
    fill_gnt     = open && fill_busy_q && (!req_valid || !rr_req_q);
    req_gnt      = open && req_valid && (!fill_busy_q || rr_req_q);
    req_ready    = req_gnt;
    req_in_range = (32'(req_addr) < CELLS);
  end

  // ---------------------------------------------------------------------------
  // Arbitration pointer and fill engine
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_req_d = rr_req_q;
    if (contended) begin
      rr_req_d = !rr_req_q;
    end
  end

  always_comb begin
    fill_busy_d  = fill_busy_q;
    fill_ptr_d   = fill_ptr_q;
    fill_color_d = fill_color_q;
    if (!fill_busy_q && fill_start) begin
      fill_busy_d  = 1'b1;
      fill_ptr_d   = '0;
      fill_color_d = fill_color;
    end else if (fill_gnt) begin
      if (fill_ptr_q == FillLast) begin
        fill_busy_d = 1'b0;
        fill_ptr_d  = '0;
      end else begin
        fill_ptr_d = fill_ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_req_q     <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_ptr_q   <= '0;
      fill_color_q <= '0;
    end else begin
      rr_req_q     <= rr_req_d;
      fill_busy_q  <= fill_busy_d;
      fill_ptr_q   <= fill_ptr_d;
      fill_color_q <= fill_color_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered VRAM write port
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_we_d   = 1'b0;
    cpu_addr_d = cpu_addr_q;
    cpu_data_d = cpu_data_q;
    req_oor_d  = 1'b0;
    if (fill_gnt) begin
      cpu_we_d   = 1'b1;
      cpu_addr_d = fill_ptr_q;
      cpu_data_d = fill_color_q;
    end else if (req_gnt) begin
      // Out-of-range requests are handshaken and dropped; only the flag is raised.
      if (req_in_range) begin
        cpu_we_d   = 1'b1;
        cpu_addr_d = req_addr;
        cpu_data_d = req_data;
      end else begin
        req_oor_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
      req_oor_q  <= 1'b0;
    end else begin
      cpu_we_q   <= cpu_we_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_data_q <= cpu_data_d;
      req_oor_q  <= req_oor_d;
    end
  end

  assign fill_busy = fill_busy_q;
  assign cpu_we    = cpu_we_q;
  assign cpu_addr  = cpu_addr_q;
  assign cpu_data  = cpu_data_q;
  assign req_oor   = req_oor_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: reset, full fill, contention, window pause/resume,
// out-of-range requests and requests held while the window is closed.
module tb_vram_write_scheduler;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 2;
  localparam int unsigned CELLS = 1200;
  localparam int unsigned WC    = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          req_ready;
  logic          req_oor;
  logic          window_open;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;

  int n_checks = 0;
  int n_fail   = 0;

  vram_write_scheduler #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .CELLS        (CELLS),
    .WINDOW_CYCLES(WC)
  ) u_dut (
    .sys_clock  (clk),
    .reset_n    (rst_n),
    .vsync_ready(vsync),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .req_oor    (req_oor),
    .window_open(window_open),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int writes, seq_err, gaps, alt_err, req_idx, req_writes, k, fill_ptr;
    int t4_err, stray, rdy_hits;
    logic started, closed_seen;
    logic [31:0] exp_a, exp_d;

    // 1: reset dominates live inputs
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    fill_start = 1'b1;
    repeat (2) @(negedge clk);
    fill_start = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_cpu_we", 32'(cpu_we), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_fill_busy", 32'(fill_busy), 0);
    check_eq("rst_window_open", 32'(window_open), 0);
    check_eq("rst_req_oor", 32'(req_oor), 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 2: full fill with colour 00, window kept alive by periodic vsync
    @(negedge clk);
    fill_start = 1'b1;
    fill_color = 2'b00;
    @(negedge clk);
    fill_start = 1'b0;
    check_eq("fill_busy_after_start", 32'(fill_busy), 1);
    check_eq("closed_before_vsync", 32'(window_open), 0);
    vsync = 1'b1;
    @(negedge clk);
    vsync   = 1'b0;
    writes  = 0;
    seq_err = 0;
    gaps    = 0;
    started = 1'b0;
    for (int i = 0; i < 1400 && writes < 1200; i++) begin
      @(negedge clk);
      if (cpu_we) begin
        if (32'(cpu_addr) != writes || cpu_data != 2'b00) seq_err++;
        writes++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      vsync = (i % 50 == 49);
    end
    vsync = 1'b0;
    check_eq("fill_write_count", 32'(writes), 1200);
    check_eq("fill_addr_data_err", 32'(seq_err), 0);
    check_eq("fill_gaps", 32'(gaps), 0);
    check_eq("fill_busy_done", 32'(fill_busy), 0);
    check_eq("window_kept_open", 32'(window_open), 1);

    // 3: fill (colour 11) contending with nine requests 565..573 colour 01
    @(negedge clk);
    vsync      = 1'b1;
    fill_start = 1'b1;
    fill_color = 2'b11;
    @(negedge clk);
    vsync      = 1'b0;
    fill_start = 1'b0;
    check_eq("fill2_busy", 32'(fill_busy), 1);
    req_idx    = 0;
    req_writes = 0;
    alt_err    = 0;
    k          = 0;
    fill_ptr   = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (cpu_we) begin
        if (k < 18) begin
          exp_a = (k % 2 == 0) ? 32'(k / 2) : 32'(565 + k / 2);
          exp_d = (k % 2 == 0) ? 32'd3 : 32'd1;
          if (32'(cpu_addr) != exp_a || 32'(cpu_data) != exp_d) alt_err++;
        end
        if (cpu_data == 2'b11) begin
          if (32'(cpu_addr) != fill_ptr) alt_err++;
          fill_ptr++;
        end else if (cpu_data == 2'b01) begin
          req_writes++;
        end else begin
          alt_err++;
        end
        k++;
      end
      req_valid  = (req_idx < 9);
      req_addr   = AW'(565 + req_idx);
      req_data   = 2'b01;
      // Must be ignored: the engine is busy and keeps colour 11.
      fill_start = (c == 3);
      fill_color = (c == 3) ? 2'b00 : 2'b11;
      #1;
      if (c == 0) check_eq("rr_fill_first", 32'(req_ready), 0);
      if (req_ready) req_idx++;
    end
    req_valid  = 1'b0;
    fill_start = 1'b0;
    check_eq("contend_alt_err", 32'(alt_err), 0);
    check_eq("contend_req_accepted", 32'(req_idx), 9);
    check_eq("contend_req_writes", 32'(req_writes), 9);
    check_eq("contend_fill_busy", 32'(fill_busy), 1);

    // 4: window closes mid-fill, engine pauses and resumes at the saved pointer
    t4_err      = 0;
    closed_seen = 1'b0;
    for (int c = 0; c < 200 && !closed_seen; c++) begin
      @(negedge clk);
      if (cpu_we) begin
        if (32'(cpu_addr) != fill_ptr || cpu_data != 2'b11) t4_err++;
        fill_ptr++;
      end
      if (!window_open) closed_seen = 1'b1;
    end
    check_eq("window_closed", 32'(closed_seen), 1);
    check_eq("pre_close_fill_err", 32'(t4_err), 0);
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (cpu_we) stray++;
    end
    check_eq("closed_no_writes", 32'(stray), 0);
    check_eq("closed_fill_busy", 32'(fill_busy), 1);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    check_eq("resume_we_latency", 32'(cpu_we), 0);
    @(negedge clk);
    check_eq("resume_we", 32'(cpu_we), 1);
    check_eq("resume_addr", 32'(cpu_addr), 32'(fill_ptr));
    check_eq("resume_data", 32'(cpu_data), 3);

    // Reset mid-fill drops everything asynchronously
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_we", 32'(cpu_we), 0);
    check_eq("async_rst_busy", 32'(fill_busy), 0);
    check_eq("async_rst_window", 32'(window_open), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6: request held while closed is not accepted until the window opens
    req_valid = 1'b1;
    req_addr  = AW'(10);
    req_data  = 2'b01;
    rdy_hits  = 0;
    repeat (500) begin
      @(negedge clk);
      #1;
      if (req_ready) rdy_hits++;
    end
    check_eq("closed_ready_hits", 32'(rdy_hits), 0);
    @(negedge clk);
    vsync = 1'b1;
    #1;
    check_eq("ready_on_vsync_cycle", 32'(req_ready), 0);
    @(negedge clk);
    vsync = 1'b0;
    #1;
    check_eq("ready_after_vsync", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("req_we", 32'(cpu_we), 1);
    check_eq("req_addr", 32'(cpu_addr), 10);
    check_eq("req_data", 32'(cpu_data), 1);

    // 5: out-of-range request handshakes, writes nothing, flags req_oor
    req_valid = 1'b1;
    req_addr  = AW'(1200);
    req_data  = 2'b11;
    #1;
    check_eq("oor_ready", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("oor_flag", 32'(req_oor), 1);
    check_eq("oor_no_we", 32'(cpu_we), 0);
    check_eq("oor_addr_hold", 32'(cpu_addr), 10);
    check_eq("oor_data_hold", 32'(cpu_data), 1);
    @(negedge clk);
    check_eq("oor_flag_drop", 32'(req_oor), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
